// File: rtl/demux_1_2_reg.sv
// Registered 1-to-2 demultiplexer with valid/ready on every port and a one-entry holding register
// per output channel. The optional drain counters are built when DEMUX_1_2_REG_CNT_EN is defined.
module demux_1_2_reg #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic             valid0_q, valid0_d;
  logic             valid1_q, valid1_d;
  logic [WIDTH-1:0] data0_q, data0_d;
  logic [WIDTH-1:0] data1_q, data1_d;

  logic ready0, ready1;
  logic accept;
  logic load0, load1;
  logic drain0, drain1;

  // A channel can take a word when it is empty or is being emptied on this same edge.
  assign ready0 = !valid0_q || out0_ready;
  assign ready1 = !valid1_q || out1_ready;

  // Only the selected channel gates acceptance, so a stalled channel never blocks the other.
  assign in_ready = !reset && (sel ? ready1 : ready0);

  assign accept = in_valid && in_ready;
  assign load0  = accept && !sel;
  assign load1  = accept && sel;
  assign drain0 = valid0_q && out0_ready;
  assign drain1 = valid1_q && out1_ready;

  always_comb begin
    valid0_d = valid0_q;
    data0_d  = data0_q;
    if (load0) begin
      valid0_d = 1'b1;
      data0_d  = in_data;
    end else if (drain0) begin
      valid0_d = 1'b0;
    end
  end

  always_comb begin
    valid1_d = valid1_q;
    data1_d  = data1_q;
    if (load1) begin
      valid1_d = 1'b1;
      data1_d  = in_data;
    end else if (drain1) begin
      valid1_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      data0_q  <= '0;
      data1_q  <= '0;
    end else begin
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
    end
  end

  assign out0_valid = valid0_q;
  assign out0_data  = data0_q;
  assign out1_valid = valid1_q;
  assign out1_data  = data1_q;

`ifdef DEMUX_1_2_REG_CNT_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  // Free-running; wraps naturally at 2^CNT_W.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (drain0) cnt0_d = cnt0_q + 1'b1;
    if (drain1) cnt1_d = cnt1_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`else
  assign cnt0 = '0;
  assign cnt1 = '0;
`endif

endmodule

// File: tb/tb_demux_1_2_reg.sv
// Directed bench for demux_1_2_reg; counter expectations follow DEMUX_1_2_REG_CNT_EN.
module tb_demux_1_2_reg;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned CNT_W = 4;
`ifdef DEMUX_1_2_REG_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             sel;
  logic             out0_valid, out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out1_valid, out1_ready;
  logic [WIDTH-1:0] out1_data;
  logic [CNT_W-1:0] cnt0, cnt1;

  int n_vec = 0;
  int n_err = 0;
  int e0 = 0;  // expected channel-0 drains since last reset
  int e1 = 0;

  demux_1_2_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .sel       (sel),
    .out0_valid(out0_valid),
    .out0_ready(out0_ready),
    .out0_data (out0_data),
    .out1_valid(out1_valid),
    .out1_ready(out1_ready),
    .out1_data (out1_data),
    .cnt0      (cnt0),
    .cnt1      (cnt1)
  );

  always #5 clk = ~clk;

  function automatic logic [CNT_W-1:0] ecnt(input int n);
    logic [CNT_W-1:0] v;
    v = n[CNT_W-1:0];
    return CntEn ? v : '0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; sel = 1'b1; in_data = 64'hFF;
    out0_ready = 1'b1; out1_ready = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    tick(); tick();
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready2 got %b want 0", in_ready); end
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    n_vec++;
    if ({out0_valid, out1_valid} !== 2'b00) begin
      n_err++; $display("FAIL rst_valid got %b%b want 00", out0_valid, out1_valid);
    end
    n_vec++;
    if (out0_data !== 64'h0 || out1_data !== 64'h0) begin
      n_err++; $display("FAIL rst_data got %h/%h want 0/0", out0_data, out1_data);
    end
    n_vec++;
    if (cnt0 !== 4'h0 || cnt1 !== 4'h0) begin
      n_err++; $display("FAIL rst_cnt got %h/%h want 0/0", cnt0, cnt1);
    end
    e0 = 0; e1 = 0;
  endtask

  task automatic test_routing();
    in_valid = 1'b1; sel = 1'b0; in_data = 64'hA5;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL route_rdy0 got %b want 1", in_ready); end
    tick();
    n_vec++;
    if (out0_valid !== 1'b1 || out0_data !== 64'hA5) begin
      n_err++; $display("FAIL route_out0 got v=%b d=%h want v=1 d=a5", out0_valid, out0_data);
    end
    sel = 1'b1; in_data = 64'h5A;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL route_rdy1 got %b want 1", in_ready); end
    tick();
    e0 = e0 + 1;
    n_vec++;
    if (out1_valid !== 1'b1 || out1_data !== 64'h5A || out0_valid !== 1'b0 || out0_data !== 64'hA5) begin
      n_err++; $display("FAIL route_out1 got v1=%b d1=%h v0=%b d0=%h want 1 5a 0 a5",
                        out1_valid, out1_data, out0_valid, out0_data);
    end
    in_valid = 1'b0;
    tick();
    e1 = e1 + 1;
    n_vec++;
    if (out1_valid !== 1'b0 || cnt0 !== ecnt(e0) || cnt1 !== ecnt(e1)) begin
      n_err++; $display("FAIL route_cnt got v1=%b c0=%h c1=%h want 0 %h %h",
                        out1_valid, cnt0, cnt1, ecnt(e0), ecnt(e1));
    end
  endtask

  task automatic test_stall();
    out0_ready = 1'b1; out1_ready = 1'b0;
    in_valid = 1'b1; sel = 1'b1; in_data = 64'h11;
    tick();
    n_vec++;
    if (out1_valid !== 1'b1 || out1_data !== 64'h11) begin
      n_err++; $display("FAIL stall_load got v=%b d=%h want 1 11", out1_valid, out1_data);
    end
    in_data = 64'h22;
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_block got %b want 0", in_ready); end
    tick();
    sel = 1'b0; in_data = 64'h33;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_iso_rdy got %b want 1", in_ready); end
    tick();
    n_vec++;
    if (out0_valid !== 1'b1 || out0_data !== 64'h33 || out1_valid !== 1'b1 || out1_data !== 64'h11) begin
      n_err++; $display("FAIL stall_iso got v0=%b d0=%h v1=%b d1=%h want 1 33 1 11",
                        out0_valid, out0_data, out1_valid, out1_data);
    end
    sel = 1'b1; in_data = 64'h22;
    out1_ready = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_release got %b want 1", in_ready); end
    tick();
    e0 = e0 + 1; e1 = e1 + 1;
    n_vec++;
    if (out1_valid !== 1'b1 || out1_data !== 64'h22 || out0_valid !== 1'b0) begin
      n_err++; $display("FAIL stall_22 got v1=%b d1=%h v0=%b want 1 22 0",
                        out1_valid, out1_data, out0_valid);
    end
    in_valid = 1'b0;
    tick();
    e1 = e1 + 1;
    n_vec++;
    if (out1_valid !== 1'b0 || cnt0 !== ecnt(e0) || cnt1 !== ecnt(e1)) begin
      n_err++; $display("FAIL stall_cnt got v1=%b c0=%h c1=%h want 0 %h %h",
                        out1_valid, cnt0, cnt1, ecnt(e0), ecnt(e1));
    end
  endtask

  task automatic test_back_to_back();
    int bad_rdy;
    int bad_data;
    bad_rdy = 0; bad_data = 0;
    out0_ready = 1'b0;
    in_valid = 1'b1; sel = 1'b0; in_data = 64'h01;
    tick();
    out0_ready = 1'b1; in_data = 64'h02;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_rdy got %b want 1", in_ready); end
    tick();
    e0 = e0 + 1;
    n_vec++;
    if (out0_valid !== 1'b1 || out0_data !== 64'h02) begin
      n_err++; $display("FAIL b2b_replace got v=%b d=%h want 1 02", out0_valid, out0_data);
    end
    for (int i = 0; i < 100; i++) begin
      in_data = 64'd1000 + 64'(i);
      #1;
      if (in_ready !== 1'b1) bad_rdy++;
      tick();
      if (out0_valid !== 1'b1 || out0_data !== 64'd1000 + 64'(i)) bad_data++;
    end
    e0 = e0 + 100;
    in_valid = 1'b0;
    tick();
    e0 = e0 + 1;
    n_vec++;
    if (bad_rdy !== 0) begin n_err++; $display("FAIL b2b_stream_rdy got %0d stalls want 0", bad_rdy); end
    n_vec++;
    if (bad_data !== 0) begin n_err++; $display("FAIL b2b_stream_data got %0d bad want 0", bad_data); end
    n_vec++;
    if (out0_valid !== 1'b0 || cnt0 !== ecnt(e0)) begin
      n_err++; $display("FAIL b2b_cnt got v=%b c0=%h want 0 %h", out0_valid, cnt0, ecnt(e0));
    end
  endtask

  task automatic test_reset_mid();
    out0_ready = 1'b0; out1_ready = 1'b0;
    in_valid = 1'b1; sel = 1'b0; in_data = 64'hAA;
    tick();
    sel = 1'b1; in_data = 64'hBB;
    tick();
    in_valid = 1'b0;
    n_vec++;
    if ({out0_valid, out1_valid} !== 2'b11) begin
      n_err++; $display("FAIL rmid_full got %b%b want 11", out0_valid, out1_valid);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    e0 = 0; e1 = 0;
    n_vec++;
    if ({out0_valid, out1_valid} !== 2'b00 || cnt0 !== 4'h0 || cnt1 !== 4'h0) begin
      n_err++; $display("FAIL rmid_clear got v=%b%b c=%h/%h want 00 0/0",
                        out0_valid, out1_valid, cnt0, cnt1);
    end
    out0_ready = 1'b1; out1_ready = 1'b1;
    tick();
    n_vec++;
    if ({out0_valid, out1_valid} !== 2'b00 || cnt0 !== 4'h0 || cnt1 !== 4'h0) begin
      n_err++; $display("FAIL rmid_ghost got v=%b%b c=%h/%h want 00 0/0",
                        out0_valid, out1_valid, cnt0, cnt1);
    end
  endtask

  task automatic test_cnt_wrap();
    out0_ready = 1'b1; out1_ready = 1'b1;
    in_valid = 1'b1; sel = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_data = 64'(i);
      tick();
    end
    n_vec++;
    if (cnt0 !== ecnt(15)) begin n_err++; $display("FAIL wrap_15 got %h want %h", cnt0, ecnt(15)); end
    in_data = 64'd16;
    tick();
    n_vec++;
    if (cnt0 !== ecnt(16)) begin n_err++; $display("FAIL wrap_0 got %h want %h", cnt0, ecnt(16)); end
    in_valid = 1'b0;
    tick();
    n_vec++;
    if (cnt0 !== ecnt(17) || cnt1 !== 4'h0) begin
      n_err++; $display("FAIL wrap_end got c0=%h c1=%h want %h 0", cnt0, cnt1, ecnt(17));
    end
  endtask

  initial begin
    test_reset();
    test_routing();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_cnt_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/demux_1_2_reg.md
Name: demux_1_2_reg

Overview:
- Registered 1-to-2 demultiplexer with valid/ready handshakes; the inverse of the 2:1 selector used in the datapath.
- Routes each accepted input word to output channel 0 or 1 according to `sel`, sampled at acceptance.
- Each channel has a one-entry holding register, so one channel can stall without blocking the other.
- Sits between a single producer (e.g. writeback result bus) and two consumers (e.g. register-file write port and forwarding/debug sink).

Parameters:
- WIDTH, 64, data width in bits of in_data/out0_data/out1_data.
- CNT_W, 16, width of per-channel transfer counters (used only with the optional feature).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  producer has a word on in_data
- in_ready  output  1  block accepts in_data this cycle
- in_data  input  WIDTH  input word
- sel  input  1  destination channel for in_data (0 -> out0, 1 -> out1); qualified by in_valid
- out0_valid  output  1  channel 0 holding register full
- out0_ready  input  1  consumer 0 takes out0_data this cycle
- out0_data  output  WIDTH  channel 0 word
- out1_valid  output  1  channel 1 holding register full
- out1_ready  input  1  consumer 1 takes out1_data this cycle
- out1_data  output  WIDTH  channel 1 word
- cnt0  output  CNT_W  completed channel-0 output transfers
- cnt1  output  CNT_W  completed channel-1 output transfers

Behaviour:
- Reset (sampled on clk rising edge while reset=1):
  - out0_valid=0, out1_valid=0, out0_data=0, out1_data=0, cnt0=0, cnt1=0.
  - in_ready=0 combinationally while reset=1.
  - Reset mid-operation discards held words; no output handshake is counted during reset.
- Per-channel state (full flag = outN_valid):
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on drain without load.
  - FULL -> FULL on drain with load (word replaced), or when neither occurs (word held).
- Drain: outN_valid & outN_ready at a clock edge.
- Load: in_valid & in_ready & (sel==N) at a clock edge; outN_data <= in_data, outN_valid <= 1.
- in_ready = !reset & (!outS_valid | outS_ready), where S = current sel. Combinational from sel, outS_valid and outS_ready.
- in_ready depends only on the selected channel. A full, stalled channel 1 does not block sel=0 traffic.
- Latency: a word accepted at edge k appears on outN_data/outN_valid immediately after edge k (1 cycle). No combinational in_data -> out path.
- Full-throughput pass-through: with outN_ready held 1 and sel held at N, one word per cycle.
- Stability: while outN_valid=1 and outN_ready=0, outN_data and outN_valid do not change.
- The non-selected channel is unaffected by input activity. It can drain on the same edge that the other channel loads.
- sel and in_data are don't-care when in_valid=0.
- Producer rule: in_valid, in_data and sel stay stable until accepted. The block does not check this.
- When a channel drains without load, outN_data keeps its last value; only valid drops.

Optional Feature:
- Macro: DEMUX_1_2_REG_CNT_EN
- Defined:
  - cnt0/cnt1 increment by 1 on each channel-0/channel-1 drain edge.
  - Free-running; wrap from 2^CNT_W-1 to 0.
  - Cleared only by reset.
  - Both may increment on the same edge.
- Not defined: cnt0 and cnt1 are tied to constant 0 and no counter flops are built. Ports remain present so instantiations are identical in both builds.

Test Plan:
1. Reset check: reset=1 for 2 cycles with in_valid=1, sel=1, in_data=64'hFF, out0_ready=out1_ready=1 -> in_ready=0; after reset out0_valid=out1_valid=0, data=0, cnt0=cnt1=0.
2. Basic routing: send 64'hA5 with sel=0, then 64'h5A with sel=1, both consumers ready -> out0 shows A5 one cycle after its accept, out1 shows 5A one cycle after its accept; with macro, cnt0=1 and cnt1=1.
3. Stall isolation: out1_ready=0, send 64'h11 sel=1 (accepted), then 64'h22 sel=1 (in_ready=0, held), then switch producer to 64'h33 sel=0 -> 33 accepted and delivered on out0 while out1_data stays 11 and out1_valid stays 1; raise out1_ready -> 11 drains, then 22 accepted.
4. Simultaneous drain/load: channel 0 full with 64'h01, out0_ready=1, in_valid=1, sel=0, in_data=64'h02 -> in_ready=1; next cycle out0_valid=1 and out0_data=02; streaming 100 consecutive words at sel=0 gives 100 transfers in 100 cycles.
5. Reset mid-operation: both channels full (out*_ready=0), assert reset for 1 cycle -> both valids 0 and counters 0 next cycle; the held words never appear.
6. Counter wrap (macro defined, CNT_W=4): 17 channel-0 drains -> cnt0 reaches 15, wraps to 0, ends at 1; cnt1 stays 0.
